// File: rtl/otter_dmem_arbiter.sv
// otter_dmem_arbiter: shares OTTER memory port 2 between the LSU (M0) and the debug loader (M1)
module otter_dmem_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        M0_REQ,
  input  logic        M0_WE,
  input  logic [31:0] M0_ADDR,
  input  logic [31:0] M0_DIN,
  input  logic [1:0]  M0_SIZE,
  input  logic        M0_SIGN,
  input  logic        M1_REQ,
  input  logic        M1_WE,
  input  logic [31:0] M1_ADDR,
  input  logic [31:0] M1_DIN,
  input  logic [1:0]  M1_SIZE,
  input  logic        M1_SIGN,
  output logic        M0_GNT,
  output logic        M1_GNT,
  output logic        M0_RVALID,
  output logic        M1_RVALID,
  output logic [31:0] M0_RDATA,
  output logic [31:0] M1_RDATA,
  output logic        MEM_RDEN2,
  output logic        MEM_WE2,
  output logic [31:0] MEM_ADDR2,
  output logic [31:0] MEM_DIN2,
  output logic [1:0]  MEM_SIZE,
  output logic        MEM_SIGN,
  input  logic [31:0] MEM_DOUT2
);
  typedef enum logic {IDLE, RDATA} state_t;
  state_t state, state_nxt;
  logic owner, last, win, go, rd, we_w, sign_w, la_sign;
  logic [31:0] addr_w, din_w, la_addr;
  logic [1:0] size_w, la_size;
  always_comb begin
    win = (M0_REQ && M1_REQ) ? (FIXED_PRIO ? 1'b0 : !last) : M1_REQ;
    go = !RST && state == IDLE && (M0_REQ || M1_REQ);
    rd = !RST && state == RDATA;
    we_w = win ? M1_WE : M0_WE;
    addr_w = win ? M1_ADDR : M0_ADDR;
    din_w = win ? M1_DIN : M0_DIN;
    size_w = win ? M1_SIZE : M0_SIZE;
    sign_w = win ? M1_SIGN : M0_SIGN;
    state_nxt = (go && !we_w) ? RDATA : IDLE;
  end
  // port 2 sizes read data from the live address/size/sign, so RDATA replays the latched copies
  assign M0_GNT = go && !win;
  assign M1_GNT = go && win;
  assign MEM_WE2 = go && we_w;
  assign MEM_RDEN2 = go && !we_w;
  assign MEM_ADDR2 = go ? addr_w : rd ? la_addr : '0;
  assign MEM_DIN2 = go ? din_w : '0;
  assign MEM_SIZE = go ? size_w : rd ? la_size : '0;
  assign MEM_SIGN = go ? sign_w : rd ? la_sign : 1'b0;
  assign M0_RVALID = rd && !owner;
  assign M1_RVALID = rd && owner;
  assign M0_RDATA = M0_RVALID ? MEM_DOUT2 : '0;
  assign M1_RDATA = M1_RVALID ? MEM_DOUT2 : '0;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      owner <= 1'b0;
      last <= 1'b1;
      la_addr <= '0;
      la_size <= '0;
      la_sign <= 1'b0;
    end else begin
      state <= state_nxt;
      if (go) last <= win;
      if (go && !we_w) begin
        owner <= win;
        la_addr <= addr_w;
        la_size <= size_w;
        la_sign <= sign_w;
      end
    end
  end
endmodule

// File: tb/tb_otter_dmem_arbiter.sv
// tb_otter_dmem_arbiter: directed vectors, corner sequences and a randomized model check
module tb_otter_dmem_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] req = '0, wr = '0, sg = '0;
  logic [31:0] adr [2];
  logic [31:0] dat [2];
  logic [1:0] sz [2];
  logic g0, g1, v0, v1, m_we, m_rd, m_sg;
  logic [31:0] rd0, rd1, m_addr, m_din, dout;
  logic [1:0] m_sz;
  logic p_g0, p_g1, p_v0, p_v1, p_we, p_rd, p_sg;
  logic [31:0] p_rd0, p_rd1, p_addr, p_din;
  logic [1:0] p_sz;
  logic [31:0] p_dout = '0;
  logic [31:0] io_in = 32'h12345678;
  logic [31:0] emem [0:255];
  logic [31:0] eword = '0, sh, wm;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  otter_dmem_arbiter #(.FIXED_PRIO(1'b0)) u0 (
    .CLK(clk), .RST(rst),
    .M0_REQ(req[0]), .M0_WE(wr[0]), .M0_ADDR(adr[0]), .M0_DIN(dat[0]), .M0_SIZE(sz[0]), .M0_SIGN(sg[0]),
    .M1_REQ(req[1]), .M1_WE(wr[1]), .M1_ADDR(adr[1]), .M1_DIN(dat[1]), .M1_SIZE(sz[1]), .M1_SIGN(sg[1]),
    .M0_GNT(g0), .M1_GNT(g1), .M0_RVALID(v0), .M1_RVALID(v1), .M0_RDATA(rd0), .M1_RDATA(rd1),
    .MEM_RDEN2(m_rd), .MEM_WE2(m_we), .MEM_ADDR2(m_addr), .MEM_DIN2(m_din), .MEM_SIZE(m_sz),
    .MEM_SIGN(m_sg), .MEM_DOUT2(dout));

  otter_dmem_arbiter #(.FIXED_PRIO(1'b1)) u1 (
    .CLK(clk), .RST(rst),
    .M0_REQ(req[0]), .M0_WE(wr[0]), .M0_ADDR(adr[0]), .M0_DIN(dat[0]), .M0_SIZE(sz[0]), .M0_SIGN(sg[0]),
    .M1_REQ(req[1]), .M1_WE(wr[1]), .M1_ADDR(adr[1]), .M1_DIN(dat[1]), .M1_SIZE(sz[1]), .M1_SIGN(sg[1]),
    .M0_GNT(p_g0), .M1_GNT(p_g1), .M0_RVALID(p_v0), .M1_RVALID(p_v1), .M0_RDATA(p_rd0), .M1_RDATA(p_rd1),
    .MEM_RDEN2(p_rd), .MEM_WE2(p_we), .MEM_ADDR2(p_addr), .MEM_DIN2(p_din), .MEM_SIZE(p_sz),
    .MEM_SIGN(p_sg), .MEM_DOUT2(p_dout));

  // port-2 memory: one-cycle registered read, combinational sizing from the live address/size/sign
  assign sh = eword >> {m_addr[1:0], 3'b000};
  assign wm = m_sz == 2'd0 ? 32'hFF : m_sz == 2'd1 ? 32'hFFFF : 32'hFFFF_FFFF;
  assign dout = m_sz == 2'd0 ? (m_sg ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]}) :
                m_sz == 2'd1 ? (m_sg ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]}) : eword;
  always @(posedge clk) begin
    if (m_we && m_addr < 32'h10000)
      emem[m_addr[9:2]] <= (emem[m_addr[9:2]] & ~(wm << {m_addr[1:0], 3'b000})) |
                           ((m_din & wm) << {m_addr[1:0], 3'b000});
    if (m_rd) eword <= m_addr >= 32'h10000 ? io_in : emem[m_addr[9:2]];
  end

  always @(negedge clk) begin
    if (m_we && m_rd) begin
      failures++;
      $display("FAIL we_rden_overlap: MEM_WE2=%b MEM_RDEN2=%b required not both 1", m_we, m_rd);
    end
    if (g0 && g1) begin
      failures++;
      $display("FAIL dual_gnt: M0_GNT=%b M1_GNT=%b required not both 1", g0, g1);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic [1:0] r, w;
    logic [31:0] a0, d0; logic [1:0] s0; logic n0;
    logic [31:0] a1, d1; logic [1:0] s1; logic n1;
    logic [1:0] g, v; logic we, rd; logic [31:0] addr, dat;
  } vec_t;
  vec_t vt [19];

  // behavioural model state: byte-addressed memory plus the pending-load record
  logic [7:0] mb [0:1023];
  bit busy, own, lst;
  logic [31:0] ed, la;
  logic [1:0] ls;
  logic ln;

  function automatic logic [31:0] mread(input logic [31:0] a, input logic [1:0] s, input logic u);
    int n = 1 << s;
    logic [31:0] v = 0;
    for (int i = 0; i < n; i++) v |= 32'(mb[a[9:0] + 10'(i)]) << (8 * i);
    if (!u && n < 4 && v[8 * n - 1]) v |= ~((32'd1 << (8 * n)) - 1);
    return v;
  endfunction

  task automatic newtx(input int i);
    req[i] = ($urandom % 3) != 0;
    wr[i] = $urandom % 2;
    sz[i] = 2'($urandom % 3);
    sg[i] = $urandom % 2;
    adr[i] = 32'h200 + (($urandom % 256) & ~((32'd1 << sz[i]) - 1));
    dat[i] = $urandom;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] eg, ev;
    logic ewe, erd, esg;
    logic [31:0] eaddr, edin, edat;
    logic [1:0] esz;
    bit w;
    for (int i = 0; i < 256; i++) emem[i] = '0;
    for (int i = 0; i < 1024; i++) mb[i] = '0;
    for (int i = 0; i < 2; i++) begin adr[i] = '0; dat[i] = '0; sz[i] = '0; end
    vt[0]  = '{2'b01, 2'b01, 32'h100, 32'hDEADBEEF, 2'd2, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 32'h100, 32'h0};
    vt[1]  = '{2'b01, 2'b00, 32'h100, 32'h0, 2'd2, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b1, 32'h100, 32'h0};
    vt[2]  = '{2'b00, 2'b00, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 32'h100, 32'hDEADBEEF};
    vt[3]  = '{2'b10, 2'b10, 32'h0, 32'h0, 2'd0, 1'b0, 32'h100, 32'h80FF0000, 2'd2, 1'b0, 2'b10, 2'b00, 1'b1, 1'b0, 32'h100, 32'h0};
    vt[4]  = '{2'b10, 2'b00, 32'h0, 32'h0, 2'd0, 1'b0, 32'h103, 32'h0, 2'd0, 1'b0, 2'b10, 2'b00, 1'b0, 1'b1, 32'h103, 32'h0};
    vt[5]  = '{2'b00, 2'b00, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0, 32'h0, 2'd2, 1'b1, 2'b00, 2'b10, 1'b0, 1'b0, 32'h103, 32'hFFFFFF80};
    vt[6]  = '{2'b01, 2'b00, 32'h102, 32'h0, 2'd1, 1'b1, 32'h0, 32'h0, 2'd0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b1, 32'h102, 32'h0};
    vt[7]  = '{2'b00, 2'b00, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 32'h102, 32'h000080FF};
    vt[8]  = '{2'b11, 2'b11, 32'h0, 32'h11, 2'd0, 1'b0, 32'h4, 32'h22, 2'd0, 1'b0, 2'b10, 2'b00, 1'b1, 1'b0, 32'h4, 32'h0};
    vt[9]  = '{2'b11, 2'b11, 32'h0, 32'h11, 2'd0, 1'b0, 32'h5, 32'h33, 2'd0, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 32'h0, 32'h0};
    vt[10] = '{2'b11, 2'b10, 32'h0, 32'h0, 2'd2, 1'b0, 32'h5, 32'h33, 2'd0, 1'b0, 2'b10, 2'b00, 1'b1, 1'b0, 32'h5, 32'h0};
    vt[11] = '{2'b01, 2'b00, 32'h0, 32'h0, 2'd2, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b1, 32'h0, 32'h0};
    vt[12] = '{2'b10, 2'b10, 32'h0, 32'h0, 2'd0, 1'b0, 32'h6, 32'h44, 2'd0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 32'h0, 32'h11};
    vt[13] = '{2'b10, 2'b10, 32'h0, 32'h0, 2'd0, 1'b0, 32'h6, 32'h44, 2'd0, 1'b0, 2'b10, 2'b00, 1'b1, 1'b0, 32'h6, 32'h0};
    vt[14] = '{2'b01, 2'b00, 32'h4, 32'h0, 2'd2, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b1, 32'h4, 32'h0};
    vt[15] = '{2'b00, 2'b00, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 32'h4, 32'h00443322};
    vt[16] = '{2'b01, 2'b00, 32'h11000, 32'h0, 2'd2, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b1, 32'h11000, 32'h0};
    vt[17] = '{2'b00, 2'b00, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 32'h11000, 32'h12345678};
    vt[18] = '{2'b00, 2'b00, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0};

    // reset with both masters requesting: everything must be held at zero
    req = 2'b11; wr = 2'b11;
    @(negedge clk);
    chk("rst_gnt", {28'd0, p_g1, p_g0, g1, g0}, 32'h0);
    chk("rst_mem", {30'd0, m_we, m_rd}, 32'h0);
    tick();
    rst = 1'b0; req = '0; wr = '0;

    for (int k = 0; k < 19; k++) begin
      req = vt[k].r; wr = vt[k].w;
      adr[0] = vt[k].a0; dat[0] = vt[k].d0; sz[0] = vt[k].s0; sg[0] = vt[k].n0;
      adr[1] = vt[k].a1; dat[1] = vt[k].d1; sz[1] = vt[k].s1; sg[1] = vt[k].n1;
      @(negedge clk);
      chk($sformatf("v%0d_gnt", k), {30'd0, g1, g0}, {30'd0, vt[k].g});
      chk($sformatf("v%0d_rvalid", k), {30'd0, v1, v0}, {30'd0, vt[k].v});
      chk($sformatf("v%0d_we_rden", k), {30'd0, m_we, m_rd}, {30'd0, vt[k].we, vt[k].rd});
      chk($sformatf("v%0d_addr", k), m_addr, vt[k].addr);
      chk($sformatf("v%0d_rdata0", k), rd0, vt[k].v[0] ? vt[k].dat : 32'h0);
      chk($sformatf("v%0d_rdata1", k), rd1, vt[k].v[1] ? vt[k].dat : 32'h0);
      tick();
    end

    // both masters storing continuously: round-robin alternates, fixed priority always picks M0
    rst = 1'b1; req = '0; wr = '0;
    tick();
    rst = 1'b0; req = 2'b11; wr = 2'b11;
    adr[0] = 32'h300; adr[1] = 32'h304; sz[0] = 2'd2; sz[1] = 2'd2;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("rr%0d_gnt", k), {30'd0, g1, g0}, (k % 2) ? 32'd2 : 32'd1);
      chk($sformatf("fp%0d_gnt", k), {30'd0, p_g1, p_g0}, 32'd1);
      tick();
    end

    // reset landing in the data cycle drops the response and restores M0's tie win
    req = 2'b01; wr = 2'b00; adr[0] = 32'h104;
    @(negedge clk);
    chk("rstrd_load_gnt", {30'd0, g1, g0}, 32'd1);
    tick();
    rst = 1'b1; req = '0;
    @(negedge clk);
    chk("rstrd_rvalid", {30'd0, v1, v0}, 32'h0);
    chk("rstrd_rdata", rd0 | rd1, 32'h0);
    chk("rstrd_mem", {30'd0, m_we, m_rd}, 32'h0);
    chk("rstrd_addr", m_addr, 32'h0);
    tick();
    rst = 1'b0; req = 2'b11; wr = 2'b11;
    @(negedge clk);
    chk("rstrd_tie_gnt", {30'd0, g1, g0}, 32'd1);
    tick();

    // randomized traffic against the transaction-level model
    rst = 1'b1; req = '0;
    tick();
    rst = 1'b0; busy = 0; lst = 1; own = 0;
    newtx(0); newtx(1);
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom % 100) == 0;
      @(negedge clk);
      eg = '0; ev = '0; ewe = 0; erd = 0; eaddr = '0; edin = '0; esz = '0; esg = 0; edat = '0;
      if (rst) begin
        busy = 0; lst = 1;
      end else if (busy) begin
        ev[own] = 1'b1; edat = ed; eaddr = la; esz = ls; esg = ln; busy = 0;
      end else if (req != 2'b00) begin
        w = (req == 2'b11) ? !lst : req[1];
        eg[w] = 1'b1; eaddr = adr[w]; edin = dat[w]; esz = sz[w]; esg = sg[w]; lst = w;
        if (wr[w]) begin
          ewe = 1'b1;
          for (int i = 0; i < (1 << sz[w]); i++) mb[adr[w][9:0] + 10'(i)] = 8'(dat[w] >> (8 * i));
        end else begin
          erd = 1'b1; busy = 1; own = w; la = adr[w]; ls = sz[w]; ln = sg[w];
          ed = mread(adr[w], sz[w], sg[w]);
        end
      end
      chk("rnd_gnt", {30'd0, g1, g0}, {30'd0, eg});
      chk("rnd_rvalid", {30'd0, v1, v0}, {30'd0, ev});
      chk("rnd_rdata0", rd0, ev[0] ? edat : 32'h0);
      chk("rnd_rdata1", rd1, ev[1] ? edat : 32'h0);
      chk("rnd_we_rden", {30'd0, m_we, m_rd}, {30'd0, ewe, erd});
      chk("rnd_addr", m_addr, eaddr);
      chk("rnd_din", m_din, edin);
      chk("rnd_size_sign", {29'd0, m_sz, m_sg}, {29'd0, esz, esg});
      tick();
      for (int i = 0; i < 2; i++) if (eg[i] || !req[i]) newtx(i);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
